// File: rtl/riscv_fetch_unit_pkg.sv
// Shared core definitions used by the instruction fetch stage.
// Contents: datapath widths, the default reset PC, the sequential PC step,
// the {pc, instr} record stored by the prefetch FIFO, and a PC alignment helper.
package riscv_core_defs;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned; the low two bits of a requested PC are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Prefetch FIFO holding fetched {pc, instr} pairs in fetch order.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   push        write push_data (ignored when full)
//   pop         remove the head entry (ignored when empty)
//   flush       empty the FIFO; wins over push and pop in the same cycle
//   push_data   entry to write
//   head_data   oldest entry, all zeros while empty
//   count       number of stored entries
//   empty/full  occupancy flags
module riscv_fetch_fifo
  import riscv_core_defs::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  push_data,
  output fetch_entry_t  head_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Showing zeros while empty keeps the instruction outputs defined out of reset.
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: issues sequential word fetches on a pipelined
// request/response bus, buffers returned words with their PCs, and hands them
// to the core over a valid/ready interface. A redirect flushes buffered words
// and drops every response still owed for requests issued before it.
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   imem_req/addr/gnt              fetch request, word address, acceptance
//   imem_rvalid/rdata              in-order response
//   redirect_valid/pc              restart fetch at a new PC
//   instr_valid/ready/data/pc      instruction handshake towards the core
module riscv_fetch_unit
  import riscv_core_defs::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 2;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  fetch_entry_t    fifo_head;
  fetch_entry_t    fifo_in;

  logic [SW-1:0]   in_use;
  logic            grant;
  logic            rvalid_ok;
  logic            drop_resp;
  logic            keep_resp;
  logic            push;
  logic            pop;

  // Every slot is reserved at request time (buffered + owed + to-be-dropped),
  // so a response always has room in the FIFO and no backpressure is needed.
  assign in_use    = SW'(fifo_count) + SW'(outstanding) + SW'(discard);
  assign imem_req  = rstn && !redirect_valid && (in_use < SW'(DEPTH));
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;

  // A response with nothing owed is a bus protocol error and is ignored.
  assign rvalid_ok = imem_rvalid && ((outstanding != '0) || (discard != '0));
  assign drop_resp = rvalid_ok && (discard != '0);
  assign keep_resp = rvalid_ok && (discard == '0);
  assign push      = keep_resp && !redirect_valid;

  assign instr_valid = !fifo_empty && !redirect_valid;
  assign pop         = instr_valid && instr_ready;
  assign instr_data  = fifo_head.instr;
  assign instr_pc    = fifo_head.pc;
  assign fifo_in     = '{pc: resp_pc, instr: imem_rdata};

  // On redirect all requests already issued become stale: whatever is still
  // owed moves into the discard count, less the one answered this cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= align_pc(redirect_pc);
      resp_pc     <= align_pc(redirect_pc);
      outstanding <= '0;
      discard     <= discard + outstanding - CW'(rvalid_ok);
    end else begin
      if (grant) fetch_pc <= fetch_pc + PC_STEP;
      if (push)  resp_pc  <= resp_pc + PC_STEP;
      outstanding <= outstanding + CW'(grant) - CW'(keep_resp);
      discard     <= discard - CW'(drop_resp);
    end
  end

  riscv_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data (fifo_in),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rstn)
    imem_rvalid |-> ((outstanding != '0) || (discard != '0)));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    in_use <= SW'(DEPTH));

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rstn)
    !(push && fifo_full));

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Self-checking bench for riscv_fetch_unit: a bus memory model, a
// stream-level reference model checked every cycle, and directed scenarios
// with literal expectations.
module tb_riscv_fetch_unit;
  import riscv_core_defs::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  int checks   = 0;
  int failures = 0;

  int          gnt_pct  = 100;
  int          lat_min  = 1;
  int          lat_max  = 1;
  logic [31:0] data_key = 32'h0;

  int          cyc         = 0;
  int          grant_count = 0;
  logic [31:0] grant_log [$];
  logic [31:0] deliv_log [$];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;
  mem_req_t mem_q [$];
  int       last_due = 0;
  int       due;

  // reference model state
  logic [31:0] m_fetch_pc;
  logic [31:0] m_deliver_pc;
  int          m_items;
  int          m_epoch;
  int          m_tags [$];
  bit          exp_req;
  bit          exp_valid;
  int          tag;

  riscv_fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q [$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  // Memory: grants per gnt_pct, answers each accepted request in order after
  // lat_min..lat_max cycles with word = address ^ data_key.
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      mem_q.delete();
      imem_gnt    = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      last_due    = cyc;
    end else begin
      imem_gnt = ($urandom_range(99) < gnt_pct);
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_q[0].addr ^ data_key;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
      #1;
      if (imem_rvalid) void'(mem_q.pop_front());
      if (imem_req && imem_gnt) begin
        due = cyc + int'($urandom_range(lat_max, lat_min));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{imem_addr, due});
        grant_count++;
        grant_log.push_back(imem_addr);
      end
    end
  end

  // Reference model: the delivered stream is consecutive words from the
  // current stream start; slots are taken by every request not yet delivered
  // or dropped; responses tagged with an older stream are thrown away.
  always @(negedge clk) begin
    #2;
    if (!rstn) begin
      check_output("reset_imem_req",    32'(imem_req),    32'h0);
      check_output("reset_instr_valid", 32'(instr_valid), 32'h0);
      check_output("reset_instr_data",  instr_data,       32'h0);
      check_output("reset_instr_pc",    instr_pc,         32'h0);
      m_fetch_pc   = 32'h0;
      m_deliver_pc = 32'h0;
      m_items      = 0;
      m_epoch      = 0;
      m_tags.delete();
    end else begin
      exp_req   = !redirect_valid && ((m_tags.size() + m_items) < DEPTH);
      exp_valid = (m_items > 0) && !redirect_valid;
      check_output("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) check_output("imem_addr", imem_addr, m_fetch_pc);
      check_output("instr_valid", 32'(instr_valid), 32'(exp_valid));
      if (exp_valid && instr_valid) begin
        check_output("instr_pc",   instr_pc,   m_deliver_pc);
        check_output("instr_data", instr_data, m_deliver_pc ^ data_key);
      end
      if (imem_rvalid && m_tags.size() > 0) begin
        tag = m_tags.pop_front();
        if (tag == m_epoch && !redirect_valid) m_items++;
      end
      if (redirect_valid) begin
        m_epoch++;
        m_items      = 0;
        m_fetch_pc   = align_pc(redirect_pc);
        m_deliver_pc = align_pc(redirect_pc);
      end else begin
        if (exp_req && imem_gnt) begin
          m_tags.push_back(m_epoch);
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (exp_valid && instr_ready) begin
          if (instr_valid) deliv_log.push_back(instr_pc);
          m_items--;
          m_deliver_pc = m_deliver_pc + 32'd4;
        end
      end
    end
  end

  task automatic apply_stimulus(input logic redir, input logic [31:0] pc,
                                input logic ready);
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = pc;
    instr_ready    = ready;
    #3;
  endtask

  task automatic run_cycles(input int n, input logic ready);
    repeat (n) apply_stimulus(1'b0, 32'h0, ready);
  endtask

  task automatic apply_reset(input logic [31:0] key);
    @(posedge clk);
    #1;
    rstn           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    repeat (2) @(negedge clk);
    data_key    = key;
    grant_count = 0;
    grant_log.delete();
    deliv_log.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic wait_grants(input int n, input logic ready, input int limit);
    int k = 0;
    while (grant_count < n && k < limit) begin
      apply_stimulus(1'b0, 32'h0, ready);
      k++;
    end
    check_output("wait_grants", 32'(grant_count >= n), 32'h1);
  endtask

  task automatic wait_deliv(input int n, input logic ready, input int limit);
    int k = 0;
    while (deliv_log.size() < n && k < limit) begin
      apply_stimulus(1'b0, 32'h0, ready);
      k++;
    end
    check_output("wait_deliv", 32'(deliv_log.size() >= n), 32'h1);
  endtask

  initial begin
    int k;
    rstn           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;

    // Zero-wait memory, word = address: streaming start-up and throughput.
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    apply_reset(32'h0);
    wait_grants(1, 1'b1, 20);
    k = 0;
    while (deliv_log.size() == 0 && k < 20) begin
      apply_stimulus(1'b0, 32'h0, 1'b1);
      k++;
    end
    check_output("first_valid_latency", 32'(k), 32'd2);
    check_output("first_pc",   q_at(deliv_log, 0), 32'h0);
    check_output("first_data", instr_data,         32'h0);
    run_cycles(8, 1'b1);
    check_output("throughput", 32'(deliv_log.size()), 32'd9);
    check_output("addr_seq_0", q_at(grant_log, 0), 32'h0);
    check_output("addr_seq_1", q_at(grant_log, 1), 32'h4);
    check_output("addr_seq_2", q_at(grant_log, 2), 32'h8);

    // Core stalled: exactly DEPTH fetches, then drain in order.
    apply_reset(32'h1234_0000);
    run_cycles(10, 1'b0);
    check_output("stall_grants",  32'(grant_count), 32'd4);
    check_output("stall_req_low", 32'(imem_req),    32'h0);
    run_cycles(4, 1'b1);
    check_output("drain_pc0", q_at(deliv_log, 0), 32'h0);
    check_output("drain_pc1", q_at(deliv_log, 1), 32'h4);
    check_output("drain_pc2", q_at(deliv_log, 2), 32'h8);
    check_output("drain_pc3", q_at(deliv_log, 3), 32'hC);
    wait_grants(5, 1'b1, 10);

    // Redirect with two requests in flight on a 3-cycle memory.
    lat_min = 3; lat_max = 3;
    apply_reset(32'h0F0F_0000);
    wait_grants(2, 1'b1, 10);
    apply_stimulus(1'b1, 32'h0000_0100, 1'b1);
    check_output("redir_req_low",   32'(imem_req),    32'h0);
    check_output("redir_valid_low", 32'(instr_valid), 32'h0);
    deliv_log.delete();
    wait_deliv(1, 1'b1, 20);
    check_output("redir_first_pc", q_at(deliv_log, 0), 32'h0000_0100);

    // Redirect coinciding with ready and a response: nothing left to drop.
    lat_min = 1; lat_max = 1;
    apply_reset(32'h5555_0000);
    wait_grants(2, 1'b0, 10);
    apply_stimulus(1'b1, 32'h0000_0040, 1'b1);
    check_output("redir_rv_valid_low", 32'(instr_valid), 32'h0);
    deliv_log.delete();
    apply_stimulus(1'b0, 32'h0, 1'b1);
    check_output("fifo_empty_after_redir", 32'(instr_valid), 32'h0);
    wait_deliv(1, 1'b1, 20);
    check_output("redir_rv_first_pc", q_at(deliv_log, 0), 32'h0000_0040);

    // Address wrap and alignment of the redirect target.
    apply_reset(32'h0);
    apply_stimulus(1'b1, 32'hFFFF_FFF8, 1'b1);
    grant_log.delete();
    run_cycles(4, 1'b1);
    check_output("wrap_addr0", q_at(grant_log, 0), 32'hFFFF_FFF8);
    check_output("wrap_addr1", q_at(grant_log, 1), 32'hFFFF_FFFC);
    check_output("wrap_addr2", q_at(grant_log, 2), 32'h0000_0000);
    apply_stimulus(1'b1, 32'h0000_0203, 1'b1);
    grant_log.delete();
    deliv_log.delete();
    wait_deliv(1, 1'b1, 20);
    check_output("align_addr", q_at(grant_log, 0), 32'h0000_0200);
    check_output("align_pc",   q_at(deliv_log, 0), 32'h0000_0200);

    // Random grants, latencies, stalls and redirects against the model.
    gnt_pct = 50; lat_min = 1; lat_max = 4;
    apply_reset(32'hCAFE_0000);
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus($urandom_range(99) < 3, $urandom & 32'h0000_3FFF,
                     $urandom_range(99) < 70);
    end
    gnt_pct = 100;
    run_cycles(20, 1'b1);
    check_output("random_progress", 32'(deliv_log.size() > 100), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
